// File: rtl/alu_operand_sequencer.sv
// Operand fetch / execute / writeback sequencer around an external 16-bit ALU.
// Owns the register file and the A/B/C pipeline registers, plus {N,V,Z} status.
module alu_operand_sequencer #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [AW-1:0]     rn,
   input  logic [AW-1:0]     rm,
   input  logic [AW-1:0]     rd,
   input  logic [1:0]        shift,
   input  logic              use_imm,
   input  logic [DATA_W-1:0] imm,
   input  logic              write_en,
   input  logic              ext_we,
   input  logic [AW-1:0]     ext_addr,
   input  logic [DATA_W-1:0] ext_data,
   input  logic [AW-1:0]     dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_z,
   output logic              busy,
   output logic              done,
   output logic [2:0]        status
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_WRITE
   } state_t;

   localparam int MSB = DATA_W - 1;

   state_t            state_q;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] a_q, b_q, c_q, imm_q;
   logic [1:0]        op_q, shift_q;
   logic [AW-1:0]     rn_q, rm_q, rd_q;
   logic              use_imm_q, we_q;
   logic              busy_q, done_q;
   logic [2:0]        status_q;

   logic [DATA_W-1:0] b_d;
   logic              v_d;

   always_comb begin
      b_d = regs_q[rm_q];
      if (use_imm_q) begin
         b_d = imm_q;
      end else begin
         case (shift_q)
            2'b01:   b_d = {regs_q[rm_q][MSB-1:0], 1'b0};
            2'b10:   b_d = {1'b0, regs_q[rm_q][MSB:1]};
            2'b11:   b_d = {regs_q[rm_q][MSB], regs_q[rm_q][MSB:1]};
            default: b_d = regs_q[rm_q];
         endcase
      end
   end

   // Signed overflow only exists for ADD/SUB; logic ops never overflow.
   always_comb begin
      v_d = 1'b0;
      case (op_q)
         2'b00:   v_d = (a_q[MSB] == b_q[MSB]) && (alu_result[MSB] != a_q[MSB]);
         2'b01:   v_d = (a_q[MSB] != b_q[MSB]) && (alu_result[MSB] != a_q[MSB]);
         default: v_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         imm_q     <= '0;
         op_q      <= '0;
         shift_q   <= '0;
         rn_q      <= '0;
         rm_q      <= '0;
         rd_q      <= '0;
         use_imm_q <= 1'b0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         status_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // The external load lands this edge, so LOAD_A/LOAD_B see it.
               if (ext_we) regs_q[ext_addr] <= ext_data;
               if (start) begin
                  op_q      <= op;
                  rn_q      <= rn;
                  rm_q      <= rm;
                  rd_q      <= rd;
                  shift_q   <= shift;
                  use_imm_q <= use_imm;
                  imm_q     <= imm;
                  we_q      <= write_en;
                  busy_q    <= 1'b1;
                  state_q   <= S_LOAD_A;
               end
            end
            S_LOAD_A: begin
               a_q     <= regs_q[rn_q];
               state_q <= S_LOAD_B;
            end
            S_LOAD_B: begin
               b_q     <= b_d;
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               c_q      <= alu_result;
               status_q <= {alu_result[MSB], v_d, alu_z};
               done_q   <= 1'b1;
               state_q  <= S_WRITE;
            end
            S_WRITE: begin
               if (we_q) regs_q[rd_q] <= c_q;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign dbg_data = regs_q[dbg_addr];
   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign alu_op   = op_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign status   = status_q;

endmodule
